cache_memory_controller: RTL and testbench
==========================================

# cache_memory_controller

Parameterised direct-mapped, write-back, write-allocate cache controller. It sits between a CPU-side load/store port and a slow word-wide backing memory, and replaces fixed-delay memory waits with a request/acknowledge handshake of arbitrary latency. It adds three behaviours: dirty-line write-back on eviction, a whole-cache flush command, and saturating hit/miss counters.

## Interface
- CACHE_WORDS, 1024, number of one-word lines; power of two, ≥ 2
- ADDRESS_SPACE, 12, word-address width; must exceed log2(CACHE_WORDS)
- DATA_SIZE, 32, word width
- Derived: INDEX_BITS = log2(CACHE_WORDS); TAG_BITS = ADDRESS_SPACE − INDEX_BITS
- clk  in  1  clock, all logic on rising edge
- rsta_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request, sampled only while cpu_ready=1
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDRESS_SPACE  word address
- cpu_din  in  DATA_SIZE  store data
- cpu_ready  out  1  controller idle, can accept a request
- cpu_valid  out  1  one-cycle pulse: access complete
- cpu_hit  out  1  qualified by cpu_valid: 1 = hit, 0 = miss
- cpu_dout  out  DATA_SIZE  load data, qualified by cpu_valid
- flush_req  in  1  write back all dirty lines, sampled only while cpu_ready=1
- flush_done  out  1  one-cycle pulse: flush scan finished
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write-back, 0 = fetch
- mem_addr  out  ADDRESS_SPACE  memory word address
- mem_wdata  out  DATA_SIZE  write-back data
- mem_ack  in  1  one-cycle acknowledge; on a fetch, mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_SIZE  fetch data
- hit_count, miss_count  out  16  saturating event counters

## Operation
- Per line: valid, dirty, tag[TAG_BITS], data[DATA_SIZE]. The index is the low INDEX_BITS of the address; the tag is the upper bits.
- States: IDLE, COMPARE, WRITEBACK, FETCH, FLUSH, FLUSH_WB.
- IDLE: cpu_ready=1.
  - flush_req=1 → FLUSH with scan index 0. flush_req wins over a simultaneous cpu_req; the cpu_req is not accepted.
  - Otherwise cpu_req=1 → latch we/addr/din and go to COMPARE.
- COMPARE, hit (valid and tag match):
  - Load: cpu_dout = line data.
  - Store: write data and set dirty.
  - Pulse cpu_valid with cpu_hit=1, increment hit_count, return to IDLE.
- COMPARE, miss: increment miss_count.
  - Victim valid and dirty → WRITEBACK.
  - Otherwise → FETCH.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack → FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=request address. On mem_ack, install the line with valid=1 and the new tag.
  - Load: data = mem_rdata, dirty=0, cpu_dout = mem_rdata.
  - Store: data = cpu_din, dirty=1. mem_rdata is discarded.
  - Pulse cpu_valid with cpu_hit=0, then go to IDLE.
- FLUSH: examine the line at the scan index.
  - Valid and dirty → FLUSH_WB, which writes back {tag, index} and clears dirty on mem_ack. Valid stays set.
  - Otherwise advance one index per cycle.
  - After index CACHE_WORDS−1 is processed, pulse flush_done and go to IDLE.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset values (asynchronous, on rsta_n=0):
  - State = IDLE; all valid and dirty bits = 0.
  - cpu_ready=1; cpu_valid=0; cpu_hit=0; cpu_dout=0; flush_done=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - Both counters = 0.
- Reset mid-operation: mem_req drops immediately and the transaction is abandoned; dirty data is lost. The memory model must tolerate an unacknowledged request disappearing.
- Hit latency: request accepted at edge k → cpu_valid high in the cycle after edge k+1. cpu_ready returns to 1 in that same cycle.
- Miss latency: 1 cycle + fetch wait, plus write-back wait if the victim is dirty.
- All outputs are registered. mem_req and the mem_* lines are stable while mem_req=1. mem_req falls on the edge that samples mem_ack, and stays low for exactly one cycle between a write-back and the following fetch.
- mem_ack while mem_req=0 is ignored.
- A full flush with no dirty lines takes CACHE_WORDS cycles plus 1.

## Structure
- Package cache_ctrl_pkg: state enum, a clog2 function, and the counter width constant (16).
- One sub-module, cache_line_store, holds the valid/dirty/tag/data arrays. It has one read port and one write port, with asynchronous clear of the valid/dirty bits only.

## Test plan
Configuration for all scenarios: CACHE_WORDS=16, ADDRESS_SPACE=8, DATA_SIZE=32. Memory model acks after 5 cycles, and mem[a] initially = 32'hDEAD0000|a.
- Scenario 1, cold load then repeat: after reset, load 0x23.
  - Required: one fetch at 0x23 with no write-back; cpu_dout=32'hDEAD0023, cpu_hit=0, miss_count=1.
  - Repeat the load of 0x23: cpu_valid 2 cycles after acceptance, cpu_hit=1, no mem_req, hit_count=1.
- Scenario 2, dirty eviction: store 32'h11111111 to 0x23 (hit), then load 0x13 (same index 3).
  - Required: write-back at addr 0x23 with data 32'h11111111, one idle mem_req cycle, fetch at 0x13; cpu_dout=32'hDEAD0013.
- Scenario 3, store miss on a clean line: store 32'hCAFEF00D to 0x45.
  - Required: fetch only, no write-back. A subsequent load of 0x45 hits with 32'hCAFEF00D.
  - Evicting it later writes back 32'hCAFEF00D.
- Scenario 4, flush: dirty lines at indices 3 and 5, then flush_req.
  - Required: exactly two write-backs, in ascending index order, then a flush_done pulse.
  - A second flush: zero mem_req; flush_done exactly 17 cycles after acceptance.
- Scenario 5, simultaneous requests: flush_req and cpu_req asserted in the same cycle.
  - Required: flush executes first; the CPU access is accepted only after flush_done.
- Scenario 6, reset mid-fetch: assert rsta_n=0 during the fetch wait.
  - Required: mem_req=0 immediately and cpu_ready=1 after release. A load of a previously cached address misses.

Source files
------------

// File: rtl/cache_memory_controller_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
package cache_ctrl_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_FETCH,
    ST_FLUSH,
    ST_FLUSH_WB
  } ctrl_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_memory_controller_if.sv
// CPU, flush and backing-memory signal bundle for the cache controller.
interface cache_memory_controller_if #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32
);

  // Handshakes: cpu_req/flush_req are taken only on an edge where cpu_ready=1;
  // cpu_valid/flush_done are single-cycle completion pulses. mem_req is held with
  // stable mem_* until the edge that samples mem_ack, and mem_ack with mem_req=0
  // carries no meaning.
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_SPACE-1:0] cpu_addr;
  logic [DATA_SIZE-1:0]     cpu_din;
  logic                     cpu_ready;
  logic                     cpu_valid;
  logic                     cpu_hit;
  logic [DATA_SIZE-1:0]     cpu_dout;
  logic                     flush_req;
  logic                     flush_done;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_SPACE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]     mem_wdata;
  logic                     mem_ack;
  logic [DATA_SIZE-1:0]     mem_rdata;

  // master: the controller; slave: the CPU and memory environment around it.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, flush_req, mem_ack, mem_rdata,
    output cpu_ready, cpu_valid, cpu_hit, cpu_dout, flush_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din, flush_req, mem_ack, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_hit, cpu_dout, flush_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_line_store.sv
// Line arrays: one asynchronous read port, one synchronous write port.
// Only valid/dirty are cleared by reset; tag and data are meaningless until valid.
module cache_line_store #(
  parameter int WORDS      = 1024,
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 2,
  parameter int DATA_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rsta_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_SIZE-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_SIZE-1:0]  wr_data
);

  logic [WORDS-1:0]     valid_q;
  logic [WORDS-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [WORDS];
  logic [DATA_SIZE-1:0] data_q [WORDS];

  always_ff @(posedge clk or negedge rsta_n) begin
    if (!rsta_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_memory_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with flush and
// saturating hit/miss counters. All CPU and memory outputs are registered.
module cache_memory_controller
  import cache_ctrl_pkg::*;
#(
  parameter int CACHE_WORDS   = 1024,
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32
) (
  input  logic                      clk,
  input  logic                      rsta_n,
  cache_memory_controller_if.master bus,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count,
  output ctrl_state_e               dbg_state
);

  localparam int INDEX_BITS = clog2(CACHE_WORDS);
  localparam int TAG_BITS   = ADDRESS_SPACE - INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(CACHE_WORDS - 1);

  ctrl_state_e              state;
  logic                     req_we;
  logic [ADDRESS_SPACE-1:0] req_addr;
  logic [DATA_SIZE-1:0]     req_din;
  logic [INDEX_BITS-1:0]    scan_idx;

  logic                     cpu_ready_q, cpu_valid_q, cpu_hit_q, flush_done_q;
  logic [DATA_SIZE-1:0]     cpu_dout_q;
  logic                     mem_req_q, mem_we_q;
  logic [ADDRESS_SPACE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0]     mem_wdata_q;

  logic [INDEX_BITS-1:0]    req_idx, rd_idx;
  logic [TAG_BITS-1:0]      req_tag, rd_tag;
  logic                     rd_valid, rd_dirty, hit;
  logic [DATA_SIZE-1:0]     rd_data;

  logic                     wr_en, wr_valid, wr_dirty;
  logic [INDEX_BITS-1:0]    wr_idx;
  logic [TAG_BITS-1:0]      wr_tag;
  logic [DATA_SIZE-1:0]     wr_data;

  assign req_idx = req_addr[INDEX_BITS-1:0];
  assign req_tag = req_addr[ADDRESS_SPACE-1:INDEX_BITS];
  assign rd_idx  = (state == ST_FLUSH || state == ST_FLUSH_WB) ? scan_idx : req_idx;
  assign hit     = rd_valid && (rd_tag == req_tag);

  cache_line_store #(
    .WORDS      (CACHE_WORDS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_SIZE  (DATA_SIZE)
  ) u_store (
    .clk      (clk),
    .rsta_n   (rsta_n),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = req_idx;
    wr_valid = 1'b1;
    wr_dirty = 1'b1;
    wr_tag   = req_tag;
    wr_data  = req_din;
    case (state)
      ST_COMPARE: wr_en = hit && req_we;
      ST_FETCH: begin
        if (mem_req_q && bus.mem_ack) begin
          wr_en    = 1'b1;
          wr_dirty = req_we;
          wr_data  = req_we ? req_din : bus.mem_rdata;
        end
      end
      ST_FLUSH_WB: begin
        // Rewrite the line unchanged apart from the dirty bit.
        if (mem_req_q && bus.mem_ack) begin
          wr_en    = 1'b1;
          wr_idx   = scan_idx;
          wr_dirty = 1'b0;
          wr_tag   = rd_tag;
          wr_data  = rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rsta_n) begin
    if (!rsta_n) begin
      state        <= ST_IDLE;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_din      <= '0;
      scan_idx     <= '0;
      cpu_ready_q  <= 1'b1;
      cpu_valid_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_dout_q   <= '0;
      flush_done_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      cpu_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.flush_req) begin
            state       <= ST_FLUSH;
            scan_idx    <= '0;
            cpu_ready_q <= 1'b0;
          end else if (bus.cpu_req) begin
            state       <= ST_COMPARE;
            req_we      <= bus.cpu_we;
            req_addr    <= bus.cpu_addr;
            req_din     <= bus.cpu_din;
            cpu_ready_q <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (hit) begin
            cpu_valid_q <= 1'b1;
            cpu_hit_q   <= 1'b1;
            cpu_ready_q <= 1'b1;
            if (!req_we) cpu_dout_q <= rd_data;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            state <= ST_IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            mem_req_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {rd_tag, req_idx};
              mem_wdata_q <= rd_data;
              state       <= ST_WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= req_addr;
              state      <= ST_FETCH;
            end
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Arriving from a write-back, mem_req is low for this one cycle.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= req_addr;
          end else if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            cpu_valid_q <= 1'b1;
            cpu_hit_q   <= 1'b0;
            cpu_ready_q <= 1'b1;
            if (!req_we) cpu_dout_q <= bus.mem_rdata;
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (rd_valid && rd_dirty) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {rd_tag, scan_idx};
            mem_wdata_q <= rd_data;
            state       <= ST_FLUSH_WB;
          end else if (scan_idx == LAST_IDX) begin
            flush_done_q <= 1'b1;
            cpu_ready_q  <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            scan_idx <= scan_idx + INDEX_BITS'(1);
          end
        end
        ST_FLUSH_WB: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              flush_done_q <= 1'b1;
              cpu_ready_q  <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              scan_idx <= scan_idx + INDEX_BITS'(1);
              state    <= ST_FLUSH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_valid  = cpu_valid_q;
  assign bus.cpu_hit    = cpu_hit_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.flush_done = flush_done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_cache_memory_controller.sv
// Bench for cache_memory_controller: 16 lines, 8-bit word address, 32-bit data,
// backing memory that acknowledges after a programmable number of cycles.
module tb_cache_memory_controller;
  import cache_ctrl_pkg::*;

  localparam int W = 41;  // {we, addr[7:0], data[31:0]}

  logic        clk;
  logic        rsta_n;
  logic [15:0] hit_count, miss_count;
  ctrl_state_e dbg_state;

  cache_memory_controller_if #(.ADDRESS_SPACE(8), .DATA_SIZE(32)) bus ();

  cache_memory_controller #(
    .CACHE_WORDS   (16),
    .ADDRESS_SPACE (8),
    .DATA_SIZE     (32)
  ) dut (
    .clk        (clk),
    .rsta_n     (rsta_n),
    .bus        (bus.master),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [3:0]  m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] ref_mem [256];
  int          m_hits, m_misses;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit we, input logic [7:0] addr, input logic [31:0] din,
                              output bit e_hit, output logic [31:0] e_dout);
    logic [3:0] idx, tag;
    logic [7:0] victim;
    idx   = addr[3:0];
    tag   = addr[7:4];
    e_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (e_hit) begin
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        victim = {m_tag[idx], idx};
        ref_mem[victim] = m_data[idx];
        exp_q.push_back({1'b1, victim, m_data[idx]});
      end
      exp_q.push_back({1'b0, addr, 32'h0});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_data[idx]  = ref_mem[addr];
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      m_data[idx]  = din;
      m_dirty[idx] = 1'b1;
    end
    e_dout = m_data[idx];
  endtask

  task automatic model_flush();
    logic [7:0] a;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        a = {m_tag[i], 4'(i)};
        ref_mem[a] = m_data[i];
        exp_q.push_back({1'b1, a, m_data[i]});
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  // ---------------- memory responder + scoreboard ----------------
  logic [31:0] mem [256];
  int   ack_delay = 5;
  bit   spurious_ack = 0;
  int   req_cycles = 0;
  int   last_ack_cyc = 0;
  int   last_gap = 0;

  initial begin
    int wait_cnt;
    logic [W-1:0] start_txn, obs, exp_v;
    wait_cnt = 0;
    start_txn = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int a = 0; a < 256; a++) begin
      mem[a]     = 32'hDEAD0000 | a;
      ref_mem[a] = 32'hDEAD0000 | a;
    end
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!rsta_n || !bus.mem_req) begin
        wait_cnt = 0;
        if (spurious_ack && rsta_n) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hBAD0BAD0;
        end
      end else begin
        if (wait_cnt == 0) begin
          start_txn = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
          last_gap  = cyc - last_ack_cyc;
        end
        wait_cnt++;
        req_cycles++;
        if (wait_cnt >= ack_delay) begin
          checks++;
          if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== start_txn) begin
            errors++;
            $display("FAIL mem_stable: got %h want %h", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, start_txn);
          end
          obs = {bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0};
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
          bus.mem_ack  = 1'b1;
          last_ack_cyc = cyc;
          wait_cnt     = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_txn: got unexpected %h want none", obs);
          end else begin
            exp_v = exp_q.pop_front();
            if (obs !== exp_v) begin
              errors++;
              $display("FAIL mem_txn: got %h want %h", obs, exp_v);
            end
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rsta_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rsta_n = 1'b1;
  endtask

  // lat counts edges from the accepting edge to the one that raised cpu_valid, inclusive.
  task automatic cpu_access(input bit we, input logic [7:0] addr, input logic [31:0] din,
                            output bit hit, output logic [31:0] dout, output int lat, output bit tmo);
    int n;
    tmo = 0; hit = 0; dout = 'x; lat = 0; n = 0;
    @(negedge clk);
    while (!bus.cpu_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.cpu_ready) tmo = 1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.cpu_valid && n < 300) begin
      @(posedge clk); lat++;
      @(negedge clk); n++;
    end
    if (!bus.cpu_valid) tmo = 1;
    else begin hit = bus.cpu_hit; dout = bus.cpu_dout; end
  endtask

  task automatic do_flush(output int lat, output bit tmo);
    int n;
    tmo = 0; lat = 0; n = 0;
    @(negedge clk);
    while (!bus.cpu_ready && n < 300) begin @(negedge clk); n++; end
    bus.flush_req = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    n = 0;
    while (!bus.flush_done && n < 1000) begin
      @(posedge clk); lat++;
      @(negedge clk); n++;
    end
    if (!bus.flush_done) tmo = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks += 12;
    if (bus.cpu_ready !== 1'b1)  begin errors++; $display("FAIL rst_cpu_ready: got %b want 1", bus.cpu_ready); end
    if (bus.cpu_valid !== 1'b0)  begin errors++; $display("FAIL rst_cpu_valid: got %b want 0", bus.cpu_valid); end
    if (bus.cpu_hit !== 1'b0)    begin errors++; $display("FAIL rst_cpu_hit: got %b want 0", bus.cpu_hit); end
    if (bus.cpu_dout !== 32'h0)  begin errors++; $display("FAIL rst_cpu_dout: got %h want 0", bus.cpu_dout); end
    if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done: got %b want 0", bus.flush_done); end
    if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    if (bus.mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    if (bus.mem_addr !== 8'h0)   begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
    if (hit_count !== 16'h0)     begin errors++; $display("FAIL rst_hit_count: got %0d want 0", hit_count); end
    if (miss_count !== 16'h0)    begin errors++; $display("FAIL rst_miss_count: got %0d want 0", miss_count); end
    if (dbg_state !== ST_IDLE)   begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rsta_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_load();
    bit h, eh, tmo; logic [31:0] d, ed; int lat, rc;
    model_access(0, 8'h23, 0, eh, ed);
    cpu_access(0, 8'h23, 0, h, d, lat, tmo);
    checks += 4;
    if (tmo || h !== 1'b0)     begin errors++; $display("FAIL cold_hit: got %b want 0", h); end
    if (d !== 32'hDEAD0023)    begin errors++; $display("FAIL cold_dout: got %h want %h", d, 32'hDEAD0023); end
    if (lat !== 7)             begin errors++; $display("FAIL cold_latency: got %0d want 7", lat); end
    if (miss_count !== 16'd1)  begin errors++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    rc = req_cycles;
    model_access(0, 8'h23, 0, eh, ed);
    cpu_access(0, 8'h23, 0, h, d, lat, tmo);
    checks += 5;
    if (tmo || h !== eh)       begin errors++; $display("FAIL rehit_hit: got %b want %b", h, eh); end
    if (d !== ed)              begin errors++; $display("FAIL rehit_dout: got %h want %h", d, ed); end
    if (lat !== 2)             begin errors++; $display("FAIL rehit_latency: got %0d want 2", lat); end
    if (req_cycles !== rc)     begin errors++; $display("FAIL rehit_mem_req: got %0d want %0d", req_cycles, rc); end
    if (hit_count !== 16'd1)   begin errors++; $display("FAIL rehit_hit_count: got %0d want 1", hit_count); end
    checks++;
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL cold_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_dirty_evict();
    bit h, eh, tmo; logic [31:0] d, ed; int lat;
    model_access(1, 8'h23, 32'h11111111, eh, ed);
    cpu_access(1, 8'h23, 32'h11111111, h, d, lat, tmo);
    checks += 2;
    if (tmo || h !== 1'b1)     begin errors++; $display("FAIL evict_store_hit: got %b want 1", h); end
    if (lat !== 2)             begin errors++; $display("FAIL evict_store_latency: got %0d want 2", lat); end
    model_access(0, 8'h13, 0, eh, ed);
    cpu_access(0, 8'h13, 0, h, d, lat, tmo);
    checks += 5;
    if (tmo || h !== 1'b0)     begin errors++; $display("FAIL evict_hit: got %b want 0", h); end
    if (d !== 32'hDEAD0013)    begin errors++; $display("FAIL evict_dout: got %h want %h", d, 32'hDEAD0013); end
    if (lat !== 13)            begin errors++; $display("FAIL evict_latency: got %0d want 13", lat); end
    if (last_gap !== 2)        begin errors++; $display("FAIL evict_req_gap: got %0d want 2", last_gap); end
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL evict_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_store_miss();
    bit h, eh, tmo; logic [31:0] d, ed; int lat;
    model_access(1, 8'h45, 32'hCAFEF00D, eh, ed);
    cpu_access(1, 8'h45, 32'hCAFEF00D, h, d, lat, tmo);
    checks += 2;
    if (tmo || h !== 1'b0)     begin errors++; $display("FAIL smiss_hit: got %b want 0", h); end
    if (lat !== 7)             begin errors++; $display("FAIL smiss_latency: got %0d want 7", lat); end
    model_access(0, 8'h45, 0, eh, ed);
    cpu_access(0, 8'h45, 0, h, d, lat, tmo);
    checks += 2;
    if (tmo || h !== 1'b1)     begin errors++; $display("FAIL smiss_reload_hit: got %b want 1", h); end
    if (d !== 32'hCAFEF00D)    begin errors++; $display("FAIL smiss_reload_dout: got %h want CAFEF00D", d); end
    model_access(0, 8'h85, 0, eh, ed);
    cpu_access(0, 8'h85, 0, h, d, lat, tmo);
    checks += 3;
    if (tmo || h !== 1'b0)     begin errors++; $display("FAIL smiss_evict_hit: got %b want 0", h); end
    if (d !== ed)              begin errors++; $display("FAIL smiss_evict_dout: got %h want %h", d, ed); end
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL smiss_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    bit h, eh, tmo; logic [31:0] d, ed; int lat, rc;
    model_access(1, 8'h85, 32'h85858585, eh, ed);
    cpu_access(1, 8'h85, 32'h85858585, h, d, lat, tmo);
    model_access(1, 8'h13, 32'h13131313, eh, ed);
    cpu_access(1, 8'h13, 32'h13131313, h, d, lat, tmo);
    model_flush();
    do_flush(lat, tmo);
    checks += 2;
    if (tmo)                   begin errors++; $display("FAIL flush_done: got timeout want pulse"); end
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL flush_pending: got %0d want 0", exp_q.size()); end
    rc = req_cycles;
    do_flush(lat, tmo);
    checks += 2;
    if (tmo || lat !== 17)     begin errors++; $display("FAIL flush_clean_latency: got %0d want 17", lat); end
    if (req_cycles !== rc)     begin errors++; $display("FAIL flush_clean_mem_req: got %0d want %0d", req_cycles, rc); end
    @(negedge clk);
    checks++;
    if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_width: got %b want 0", bus.flush_done); end
  endtask

  task automatic test_simultaneous();
    bit h, eh, tmo; logic [31:0] d, ed; int lat, n, vcount;
    model_access(1, 8'h07, 32'h07070707, eh, ed);
    cpu_access(1, 8'h07, 32'h07070707, h, d, lat, tmo);
    model_flush();
    model_access(0, 8'h07, 0, eh, ed);
    @(negedge clk);
    n = 0;
    while (!bus.cpu_ready && n < 300) begin @(negedge clk); n++; end
    bus.flush_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h07; bus.cpu_din = '0;
    @(posedge clk);
    @(negedge clk);
    bus.flush_req = 1'b0;
    n = 0; vcount = 0;
    while (!bus.flush_done && n < 1000) begin
      if (bus.cpu_valid) vcount++;
      @(negedge clk); n++;
    end
    checks += 2;
    if (!bus.flush_done)       begin errors++; $display("FAIL simul_flush_done: got timeout want pulse"); end
    if (vcount !== 0)          begin errors++; $display("FAIL simul_early_cpu: got %0d want 0", vcount); end
    lat = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (lat == 1) bus.cpu_req = 1'b0;
      if (bus.cpu_valid) break;
    end
    bus.cpu_req = 1'b0;
    checks += 4;
    if (lat !== 2)             begin errors++; $display("FAIL simul_cpu_latency: got %0d want 2", lat); end
    if (bus.cpu_hit !== eh)    begin errors++; $display("FAIL simul_cpu_hit: got %b want %b", bus.cpu_hit, eh); end
    if (bus.cpu_dout !== ed)   begin errors++; $display("FAIL simul_cpu_dout: got %h want %h", bus.cpu_dout, ed); end
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL simul_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    bit h, eh, tmo; logic [31:0] d, ed; int n, lat;
    model_access(0, 8'h99, 0, eh, ed);
    @(negedge clk);
    n = 0;
    while (!bus.cpu_ready && n < 300) begin @(negedge clk); n++; end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h99;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bus.mem_req)          begin errors++; $display("FAIL midrst_fetch_start: got 0 want 1"); end
    repeat (2) @(negedge clk);
    #2 rsta_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0)  begin errors++; $display("FAIL midrst_mem_req: got %b want 0", bus.mem_req); end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rsta_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL midrst_cpu_ready: got %b want 1", bus.cpu_ready); end
    if (dbg_state !== ST_IDLE)  begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    model_access(0, 8'h13, 0, eh, ed);
    cpu_access(0, 8'h13, 0, h, d, lat, tmo);
    checks += 3;
    if (tmo || h !== 1'b0)     begin errors++; $display("FAIL midrst_reload_hit: got %b want 0", h); end
    if (d !== ed)              begin errors++; $display("FAIL midrst_reload_dout: got %h want %h", d, ed); end
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL midrst_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit h, eh, tmo, we; logic [31:0] d, ed, din; logic [7:0] addr; int lat;
    spurious_ack = 1;
    for (int i = 0; i < 120; i++) begin
      ack_delay = $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0) begin
        model_flush();
        do_flush(lat, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL rand_flush_%0d: got timeout want pulse", i); end
      end else begin
        we   = 1'($urandom_range(0, 1));
        addr = 8'($urandom_range(0, 63));
        din  = $urandom;
        model_access(we, addr, din, eh, ed);
        cpu_access(we, addr, din, h, d, lat, tmo);
        checks++;
        if (tmo || h !== eh) begin errors++; $display("FAIL rand_hit_%0d: addr %h got %b want %b", i, addr, h, eh); end
        if (!we) begin
          checks++;
          if (d !== ed) begin errors++; $display("FAIL rand_dout_%0d: addr %h got %h want %h", i, addr, d, ed); end
        end
      end
    end
    spurious_ack = 0;
    ack_delay = 5;
    checks += 3;
    if (exp_q.size() !== 0)            begin errors++; $display("FAIL rand_pending: got %0d want 0", exp_q.size()); end
    if (hit_count !== 16'(m_hits))     begin errors++; $display("FAIL rand_hit_count: got %0d want %0d", hit_count, m_hits); end
    if (miss_count !== 16'(m_misses))  begin errors++; $display("FAIL rand_miss_count: got %0d want %0d", miss_count, m_misses); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rsta_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.flush_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_cold_load();
    test_dirty_evict();
    test_store_miss();
    test_flush();
    test_simultaneous();
    test_reset_mid_fetch();
    apply_reset();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
